// File: rtl/nrisc_busca_instrucao.sv
// nrisc_busca_instrucao: instruction-fetch unit of the nRisc monocycle core.
//   Holds the program ROM, the PC and the run state. A program is shifted in through the
//   serial load port after reset, after which the unit fetches rom[pc] every cycle and
//   computes the next PC from the control decoder outputs and the ULA zero flag.
// Optional feature: define NRISC_PASSO_EN to add the single-step input `passo`.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   passo               (NRISC_PASSO_EN only) RUN advances only on edges where passo=1
//   carga_valido/dado   load word strobe and data, written to rom[wptr] in LOAD
//   carga_fim           end of program load, enters RUN with pc=0
//   carga_pronto        high exactly while in LOAD
//   EscPC, Jump, BEQ    control decoder outputs (EscPC=0 means HALT)
//   ZeroULA             ULA zero flag, branch taken when 1
//   instrucao, opcode, imediato  current instruction word and its fields
//   pc                  current program counter
//   parado              core halted
module nrisc_busca_instrucao #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
`ifdef NRISC_PASSO_EN
    input  logic                   passo,
`endif
    input  logic                   carga_valido,
    input  logic [INSTR_WIDTH-1:0] carga_dado,
    input  logic                   carga_fim,
    output logic                   carga_pronto,
    input  logic                   EscPC,
    input  logic                   Jump,
    input  logic                   BEQ,
    input  logic                   ZeroULA,
    output logic [INSTR_WIDTH-1:0] instrucao,
    output logic [2:0]             opcode,
    output logic [INSTR_WIDTH-4:0] imediato,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   parado
);

    localparam int unsigned ImmWidth = INSTR_WIDTH - 3;
    localparam int unsigned RomDepth = 2 ** PC_WIDTH;

    // HALT opcode with zero immediate; shown outside RUN so control deasserts all writes.
    localparam logic [INSTR_WIDTH-1:0] InstrHalt = {3'b110, {ImmWidth{1'b0}}};

    typedef enum logic [1:0] {
        StLoad,
        StRun,
        StHalted
    } state_e;

    state_e                   state;
    logic [PC_WIDTH-1:0]      wptr;
    logic [INSTR_WIDTH-1:0]   rom [RomDepth];
    logic                     passo_en;
    logic                     rom_we;
    logic [PC_WIDTH-1:0]      pc_inc;
    logic [PC_WIDTH-1:0]      pc_desvio;
    logic [PC_WIDTH-1:0]      imm_ext;

`ifdef NRISC_PASSO_EN
    assign passo_en = passo;
`else
    assign passo_en = 1'b1;
`endif

    // Combinational fetch; the word is replaced by HALT outside RUN.
    assign instrucao    = (state == StRun) ? rom[pc] : InstrHalt;
    assign opcode       = instrucao[INSTR_WIDTH-1 -: 3];
    assign imediato     = instrucao[ImmWidth-1:0];
    assign carga_pronto = (state == StLoad);
    assign parado       = (state == StHalted);

    assign rom_we    = (state == StLoad) && carga_valido;
    assign imm_ext   = {{(PC_WIDTH - ImmWidth){imediato[ImmWidth-1]}}, imediato};
    assign pc_inc    = pc + 1'b1;
    assign pc_desvio = pc_inc + imm_ext;  // wraps modulo 2**PC_WIDTH

    // ROM storage survives reset on purpose.
    always_ff @(posedge clock) begin
        if (rom_we) begin
            rom[wptr] <= carga_dado;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= StLoad;
            pc    <= '0;
            wptr  <= '0;
        end else begin
            unique case (state)
                StLoad: begin
                    if (carga_valido) begin
                        wptr <= wptr + 1'b1;
                    end
                    // Writing the last address starts the program without carga_fim.
                    if (carga_fim || (carga_valido && (wptr == {PC_WIDTH{1'b1}}))) begin
                        state <= StRun;
                        pc    <= '0;
                    end
                end
                StRun: begin
                    if (passo_en) begin
                        if (!EscPC) begin
                            state <= StHalted;
                        end else if (Jump || (BEQ && ZeroULA)) begin
                            pc <= pc_desvio;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                StHalted: begin
                    state <= StHalted;
                end
                default: begin
                    state <= StLoad;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrisc_busca_instrucao.sv
// Directed bench for nrisc_busca_instrucao. A small control-decoder model drives
// EscPC/Jump/BEQ from the fetched opcode (HALT=110, JUMP=100, BEQ=011).
module tb_nrisc_busca_instrucao;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       passo = 1'b1;
    logic       carga_valido = 1'b0;
    logic [7:0] carga_dado = 8'h00;
    logic       carga_fim = 1'b0;
    logic       carga_pronto;
    logic       EscPC, Jump, BEQ;
    logic       ZeroULA = 1'b0;
    logic [7:0] instrucao;
    logic [2:0] opcode;
    logic [4:0] imediato;
    logic [7:0] pc;
    logic       parado;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // Control decoder model
    assign EscPC = (opcode != 3'b110);
    assign Jump  = (opcode == 3'b100);
    assign BEQ   = (opcode == 3'b011);

    nrisc_busca_instrucao #(
        .PC_WIDTH   (8),
        .INSTR_WIDTH(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef NRISC_PASSO_EN
        .passo       (passo),
`endif
        .carga_valido(carga_valido),
        .carga_dado  (carga_dado),
        .carga_fim   (carga_fim),
        .carga_pronto(carga_pronto),
        .EscPC       (EscPC),
        .Jump        (Jump),
        .BEQ         (BEQ),
        .ZeroULA     (ZeroULA),
        .instrucao   (instrucao),
        .opcode      (opcode),
        .imediato    (imediato),
        .pc          (pc),
        .parado      (parado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [7:0] d, input logic fim);
        carga_valido = 1'b1;
        carga_dado   = d;
        carga_fim    = fim;
        tick();
        carga_valido = 1'b0;
        carga_fim    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_prog_beq();
        load_word(8'h62, 1'b0);
        load_word(8'h20, 1'b0);
        load_word(8'hC0, 1'b0);
        load_word(8'hC0, 1'b1);
    endtask

    initial begin
        // 1. reset state, checked while reset is still high
        tick();
        tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_pronto", 32'(carga_pronto), 32'h1);
        chk("rst_opcode", 32'(opcode), 32'h6);
        chk("rst_imediato", 32'(imediato), 32'h0);
        chk("rst_instr", 32'(instrucao), 32'hC0);
        chk("rst_parado", 32'(parado), 32'h0);
        reset = 1'b0;

        // 2. jump loop: rom = {20, 9E}; pc alternates 0,1
        load_word(8'h20, 1'b0);
        chk("load_pronto", 32'(carga_pronto), 32'h1);
        chk("load_forced", 32'(instrucao), 32'hC0);
        load_word(8'h9E, 1'b1);
        chk("run_pronto", 32'(carga_pronto), 32'h0);
        chk("run_pc0", 32'(pc), 32'h0);
        chk("run_instr0", 32'(instrucao), 32'h20);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("jump_pc", 32'(pc), 32'(i % 2));
        end
        chk("jump_instr", 32'(instrucao), 32'h20);
        tick();
        chk("jump_instr1", 32'(instrucao), 32'h9E);
        chk("jump_imm", 32'(imediato), 32'h1E);

        // 3. BEQ +2 taken
        do_reset();
        load_prog_beq();
        ZeroULA = 1'b1;
        chk("beq_instr", 32'(instrucao), 32'h62);
        tick();
        chk("beq_taken_pc", 32'(pc), 32'h3);
        tick();
        chk("beq_taken_halt", 32'(parado), 32'h1);
        chk("beq_taken_pc_hold", 32'(pc), 32'h3);

        // 3/4. BEQ not taken, then HALT at pc=2
        do_reset();
        chk("rst2_pc", 32'(pc), 32'h0);
        chk("rst2_pronto", 32'(carga_pronto), 32'h1);
        chk("rst2_parado", 32'(parado), 32'h0);
        load_prog_beq();
        ZeroULA = 1'b0;
        tick();
        chk("beq_nt_pc", 32'(pc), 32'h1);
        tick();
        chk("pc2", 32'(pc), 32'h2);
        chk("pc2_parado", 32'(parado), 32'h0);
        tick();
        chk("halt_parado", 32'(parado), 32'h1);
        chk("halt_opcode", 32'(opcode), 32'h6);
        carga_valido = 1'b1;
        carga_fim    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_pc", 32'(pc), 32'h2);
        end
        chk("halt_pronto", 32'(carga_pronto), 32'h0);
        chk("halt_parado_hold", 32'(parado), 32'h1);
        carga_valido = 1'b0;
        carga_fim    = 1'b0;

        // 5. fill all 256 words, auto-RUN on last write, pc wraps
        do_reset();
        for (int i = 0; i < 255; i++) begin
            load_word(8'h20, 1'b0);
        end
        chk("fill_pronto", 32'(carga_pronto), 32'h1);
        load_word(8'h20, 1'b0);
        chk("auto_run_pronto", 32'(carga_pronto), 32'h0);
        chk("auto_run_pc", 32'(pc), 32'h0);
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        chk("pc_255", 32'(pc), 32'hFF);
        chk("pc_255_instr", 32'(instrucao), 32'h20);
        tick();
        chk("pc_wrap", 32'(pc), 32'h0);
        chk("wrap_parado", 32'(parado), 32'h0);

        // 6. reset mid-load, reload from address 0
        do_reset();
        load_word(8'h9E, 1'b0);
        load_word(8'h9E, 1'b0);
        reset = 1'b1;
        tick();
        chk("midrst_pc", 32'(pc), 32'h0);
        chk("midrst_pronto", 32'(carga_pronto), 32'h1);
        reset = 1'b0;
        load_word(8'hC0, 1'b1);
        chk("reload_instr", 32'(instrucao), 32'hC0);
        chk("reload_parado", 32'(parado), 32'h0);
        chk("reload_pronto", 32'(carga_pronto), 32'h0);
`ifdef NRISC_PASSO_EN
        passo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("passo_hold_parado", 32'(parado), 32'h0);
            chk("passo_hold_instr", 32'(instrucao), 32'hC0);
        end
        passo = 1'b1;
`endif
        tick();
        chk("reload_halt", 32'(parado), 32'h1);
        chk("reload_halt_pc", 32'(pc), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
